inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: COUNT_W, default 16, width of the emitted-instruction counter.
REQ-002 Port: clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  upstream request valid.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7=illegal.
REQ-007 Port: opcode  input  7  placed in inst[6:0].
REQ-008 Port: rd, rs1, rs2  input  5 each  register fields.
REQ-009 Port: funct3  input  3; funct7  input  7  function fields.
REQ-010 Port: imm  input  32  signed byte-offset or value immediate.
REQ-011 Port: out_valid  output  1  inst/range_err valid.
REQ-012 Port: out_ready  input  1  downstream accepts the output.
REQ-013 Port: inst  output  32  encoded RV32 instruction word.
REQ-014 Port: range_err  output  1  imm not representable in fmt, or fmt illegal; qualified by out_valid.
REQ-015 Port: enc_count  output  COUNT_W  number of completed output transfers.

Function
REQ-016 Single-entry output register; two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 in_ready SHALL equal (!out_valid || out_ready), purely combinational.
REQ-018 Accept = in_valid && in_ready; the encoded word appears on inst with out_valid=1 on the cycle after accept (latency 1).
REQ-019 EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL with a new word loaded when drain and accept coincide (throughput 1 word/cycle).
REQ-020 inst, range_err and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 R: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-022 I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-023 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-024 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-025 U: {imm[31:12], rd, opcode}.
REQ-026 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-027 Range check: I/S require imm[31:11] all equal; B requires imm[31:12] all equal and imm[0]=0; J requires imm[31:20] all equal and imm[0]=0; U requires imm[11:0]=0; R never errors.
REQ-028 On a range error the truncated encoding per REQ-021..026 SHALL still be emitted with range_err=1.
REQ-029 Illegal fmt: inst=32'h0, range_err=1.
REQ-030 enc_count increments by 1 on each out_valid && out_ready cycle; wraps from all-ones to 0.

Reset
REQ-031 rst_n low SHALL immediately force out_valid=0, inst=0, range_err=0, enc_count=0, state EMPTY, regardless of clk.
REQ-032 A word held in FULL when rst_n asserts SHALL be discarded; in_ready=1 during and after reset.
REQ-033 First accept is permitted on the first rising clk edge after rst_n deasserts.

Verification
REQ-034 fmt=1, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> next cycle inst=32'h00500093, range_err=0, out_valid=1.
REQ-035 fmt=3, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> inst=32'hFE208EE3, range_err=0.
REQ-036 fmt=4, opcode=0110111, rd=5, imm=32'h12345000 -> inst=32'h123452B7; same with imm=32'h12345001 -> range_err=1.
REQ-037 fmt=5, imm=3 -> range_err=1; fmt=6 -> inst=0, range_err=1.
REQ-038 out_ready=0 while FULL -> in_ready=0, inst held 5 cycles; then out_ready=1 with continuous in_valid -> one word per cycle, enc_count increments each cycle.
REQ-039 rst_n low mid-cycle while FULL with enc_count=7 -> out_valid=0 and enc_count=0 before the next clk edge.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32 instruction encoder with a single-entry valid/ready output register.
// Packs R/I/S/B/U/J fields and flags immediates that the chosen format cannot represent.
//
// state    | meaning
// ST_EMPTY | no word held, out_valid=0
// ST_FULL  | encoded word held on inst/range_err, out_valid=1
module inst_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        inst,
  output logic               range_err,
  output logic [COUNT_W-1:0] enc_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [0:0]  state;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        accept;
  logic        drain;

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Sign-extension checks: the bits above the field's sign bit must all match it.
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: begin
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      inst      <= 32'h0;
      range_err <= 1'b0;
    end else if (accept) begin
      state     <= ST_FULL;
      inst      <= enc_word;
      range_err <= enc_err;
    end else if (drain) begin
      state <= ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (drain) begin
      enc_count <= enc_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, range errors,
// back-pressure, back-to-back throughput, counter wrap and asynchronous reset.
module tb_inst_encoder;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   inst;
  logic          range_err;
  logic [CW-1:0] enc_count;

  int vectors;
  int miscompares;

  inst_encoder #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .range_err (range_err),
    .enc_count (enc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] w, input logic e, input logic [CW-1:0] c);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_inst"}, inst, w);
    check({tag, "_err"}, {31'b0, range_err}, {31'b0, e});
    check({tag, "_cnt"}, {28'b0, enc_count}, {28'b0, c});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;

    #2;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_err", {31'b0, range_err}, 32'd0);
    check("rst_cnt", {28'b0, enc_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #10 rst_n = 1'b1;

    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    expect_out("i_addi", 32'h00500093, 1'b0, 4'd0);
    drive(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    tick();
    expect_out("b_neg4", 32'hFE208EE3, 1'b0, 4'd1);
    drive(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    expect_out("u_ok", 32'h123452B7, 1'b0, 4'd2);
    drive(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    tick();
    expect_out("u_low", 32'h123452B7, 1'b1, 4'd3);
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    expect_out("j_odd", 32'h002000EF, 1'b1, 4'd4);
    drive(3'd6, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    tick();
    expect_out("fmt6", 32'h0, 1'b1, 4'd5);
    drive(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hFFFFFFFF);
    tick();
    expect_out("r_sub", 32'h403100B3, 1'b0, 4'd6);
    drive(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    expect_out("s_sw", 32'h0020A423, 1'b0, 4'd7);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
    tick();
    expect_out("i_min", 32'h80000093, 1'b0, 4'd8);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    expect_out("i_over", 32'h80000093, 1'b1, 4'd9);
    drive(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd1);
    tick();
    expect_out("b_odd", 32'h00208063, 1'b1, 4'd10);

    // Stall with a competing request pending: nothing may move.
    out_ready = 1'b0;
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    #1;
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("stall", 32'h00208063, 1'b1, 4'd10);
      check("stall_in_ready_hold", {31'b0, in_ready}, 32'd0);
    end

    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imm = 32'(k * 4);
      tick();
      expect_out("b2b", 32'h00000093 | (32'(k * 4) << 20), 1'b0, 4'(11 + k));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_cnt", {28'b0, enc_count}, 32'd15);

    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    check("pre_wrap_cnt", {28'b0, enc_count}, 32'd15);
    tick();
    check("wrap_cnt", {28'b0, enc_count}, 32'd0);
    check("wrap_valid", {31'b0, out_valid}, 32'd0);

    // Build up enc_count=7 while FULL, then reset mid-cycle.
    for (int k = 0; k < 8; k++) begin
      drive(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    expect_out("pre_rst", 32'h00700113, 1'b0, 4'd7);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_cnt", {28'b0, enc_count}, 32'd0);
    check("async_rst_inst", inst, 32'h0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("rst_hold_valid", {31'b0, out_valid}, 32'd0);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    expect_out("first_after_rst", 32'h00500093, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
